// File: rtl/taillight_switch_conditioner_if.sv
// ---------------------------------------------------------------------------
// taillight_switch_conditioner_if
//   Groups the signals between the switch conditioner and its surroundings.
//   Clock and reset are not part of the bundle.
//
//   Enable  : one-cycle 1 Hz tick shared with the taillight FSM
//   SwIn    : raw asynchronous switches, [2]=left [1]=right [0]=hazard
//   L/R/H   : committed one-hot turn/hazard request to the FSM
//   Changed : one-cycle pulse when a new committed mode becomes visible
//
//   master : drives Enable/SwIn and observes the requests (board/testbench)
//   slave  : the conditioner itself
// ---------------------------------------------------------------------------
interface taillight_switch_conditioner_if;
  logic       Enable;
  logic [2:0] SwIn;
  logic       L;
  logic       R;
  logic       H;
  logic       Changed;

  modport master (
    output Enable, SwIn,
    input  L, R, H, Changed
  );

  modport slave (
    input  Enable, SwIn,
    output L, R, H, Changed
  );
endinterface

// File: rtl/taillight_switch_conditioner.sv
// ---------------------------------------------------------------------------
// taillight_switch_conditioner
//   Synchronizes and debounces the three raw board switches, decodes them
//   into one mode and commits that mode to one-hot L/R/H levels. Ordinary
//   mode changes wait for the Enable tick so the FSM never sees a request
//   change mid-phase; a hazard request commits on the next clock.
//
//   Ports:
//     Clock : system clock (50 MHz)
//     Reset : synchronous, active-high
//     bus   : taillight_switch_conditioner_if.slave (Enable, SwIn in;
//             L, R, H, Changed out)
//
//   Parameters:
//     DEBOUNCE_CYCLES : consecutive disagreeing cycles before a switch
//                       value is accepted (>= 2)
//     CNT_W           : debounce counter width
//
//   Build option:
//     SWCOND_CONFLICT_HAZARD_EN : when defined, left+right together decode
//     to HAZARD; otherwise they decode to IDLE.
// ---------------------------------------------------------------------------
module taillight_switch_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                           Clock,
  input  logic                           Reset,
  taillight_switch_conditioner_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_LEFT   = 2'd1,
    MODE_RIGHT  = 2'd2,
    MODE_HAZARD = 2'd3
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Two-flop synchronizer per switch bit.
  logic [2:0]       sync1_q, sync1_d;
  logic [2:0]       sync2_q, sync2_d;
  // Debounced level and per-bit disagreement counter.
  logic [2:0]       db_q, db_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  // Committed mode, its one-hot {L,R,H} image and the change pulse.
  mode_e            mode_q, mode_d;
  mode_e            pend_mode;
  logic [2:0]       lrh_q, lrh_d;
  logic             changed_q, changed_d;

  // NOTE: every signal written here gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    sync1_d = bus.SwIn;
    sync2_d = sync1_q;

    // Debounce: the counter only advances while the synchronized bit
    // disagrees; one agreeing cycle clears it, rejecting short glitches.
    db_d = db_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        db_d[i]  = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end

    // Priority decode of the debounced switches.
    pend_mode = MODE_IDLE;
    if (db_q[0]) begin
      pend_mode = MODE_HAZARD;
    end else if (db_q[2] && db_q[1]) begin
`ifdef SWCOND_CONFLICT_HAZARD_EN
      pend_mode = MODE_HAZARD;
`else
      pend_mode = MODE_IDLE;
`endif
    end else if (db_q[2]) begin
      pend_mode = MODE_LEFT;
    end else if (db_q[1]) begin
      pend_mode = MODE_RIGHT;
    end

    // Entering hazard bypasses the tick; everything else, including
    // leaving hazard, waits for Enable.
    mode_d = mode_q;
    if (pend_mode == MODE_HAZARD && mode_q != MODE_HAZARD) begin
      mode_d = pend_mode;
    end else if (pend_mode != mode_q && bus.Enable) begin
      mode_d = pend_mode;
    end

    lrh_d = 3'b000;
    unique case (mode_d)
      MODE_IDLE:   lrh_d = 3'b000;
      MODE_LEFT:   lrh_d = 3'b100;
      MODE_RIGHT:  lrh_d = 3'b010;
      MODE_HAZARD: lrh_d = 3'b001;
      default:     lrh_d = 3'b000;
    endcase

    changed_d = (mode_d != mode_q);
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      // NOTE: the counter array is reset explicitly; a switch held through
      // reset must then serve a full debounce interval again.
      cnt_q     <= '{default: '0};
      mode_q    <= MODE_IDLE;
      lrh_q     <= 3'b000;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      lrh_q     <= lrh_d;
      changed_q <= changed_d;
    end
  end

  assign bus.L       = lrh_q[2];
  assign bus.R       = lrh_q[1];
  assign bus.H       = lrh_q[0];
  assign bus.Changed = changed_q;

endmodule

// File: tb/tb_taillight_switch_conditioner.sv
// ---------------------------------------------------------------------------
// tb_taillight_switch_conditioner
//   Directed bench for taillight_switch_conditioner with DEBOUNCE_CYCLES=4.
//   Outputs are observed 1 time unit after each rising edge as the 4-bit
//   vector {L,R,H,Changed}. Edge numbers count rising edges from the start
//   of each scenario (cycle 0 precedes edge 1); with the automatic tick,
//   Enable is high at edges 10, 20, 30, ...
// ---------------------------------------------------------------------------
module tb_taillight_switch_conditioner;

  logic Clock;
  logic Reset;
  int   total = 0;
  int   bad   = 0;
  int   gcyc  = 0;
  logic auto_en = 1'b1;

  taillight_switch_conditioner_if sw_if ();

  taillight_switch_conditioner #(
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (sw_if.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [3:0] outs();
    return {sw_if.L, sw_if.R, sw_if.H, sw_if.Changed};
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed {L,R,H,Chg}=%b expected=%b", tag, obs, exp);
      end
  endtask

  // One rising edge with Enable from the automatic 10-cycle tick.
  task automatic step();
    sw_if.Enable = auto_en && ((gcyc % 10) == 9);
    @(posedge Clock);
    #1;
    sw_if.Enable = 1'b0;
    gcyc++;
  endtask

  // One rising edge with Enable forced to a given value.
  task automatic step_en(input logic en);
    sw_if.Enable = en;
    @(posedge Clock);
    #1;
    sw_if.Enable = 1'b0;
    gcyc++;
  endtask

  // Two reset edges, then release; the caller's next edge is edge 1.
  task automatic do_reset(input logic [2:0] sw);
    Reset        = 1'b1;
    sw_if.SwIn   = 3'b000;
    sw_if.Enable = 1'b0;
    repeat (2) begin
      @(posedge Clock);
      #1;
    end
    Reset      = 1'b0;
    sw_if.SwIn = sw;
    gcyc       = 0;
  endtask

  initial begin
    Reset        = 1'b1;
    sw_if.SwIn   = 3'b111;
    sw_if.Enable = 1'b1;

    // 1. Reset with all switches on and Enable high: all outputs stay low.
    for (int e = 1; e <= 3; e++) begin
      @(posedge Clock);
      #1;
      check($sformatf("reset_e%0d", e), outs(), 4'b0000);
    end
    Reset = 1'b0;
    sw_if.Enable = 1'b0;
    @(posedge Clock);
    #1;
    check("reset_first_post", outs(), 4'b0000);

    // 2. Left: db[2] set at edge 6, committed at the Enable edge 10.
    auto_en = 1'b1;
    do_reset(3'b100);
    for (int e = 1; e <= 9; e++) begin
      step();
      check($sformatf("left_wait_e%0d", e), outs(), 4'b0000);
    end
    step();
    check("left_commit_e10", outs(), 4'b1001);
    step();
    check("left_hold_e11", outs(), 4'b1000);

    // 3. Right glitches of 3 cycles never reach the debounce threshold.
    do_reset(3'b000);
    for (int k = 0; k < 5; k++) begin
      sw_if.SwIn = 3'b010;
      repeat (3) begin
        step();
        check($sformatf("glitch_hi_%0d", k), outs(), 4'b0000);
      end
      sw_if.SwIn = 3'b000;
      repeat (3) begin
        step();
        check($sformatf("glitch_lo_%0d", k), outs(), 4'b0000);
      end
    end

    // 4. Hazard commits without Enable; leaving hazard needs a tick.
    auto_en = 1'b0;
    do_reset(3'b001);
    for (int e = 1; e <= 6; e++) begin
      step();
      check($sformatf("haz_wait_e%0d", e), outs(), 4'b0000);
    end
    step();
    check("haz_commit_e7", outs(), 4'b0011);
    step();
    check("haz_hold_e8", outs(), 4'b0010);
    sw_if.SwIn = 3'b000;
    for (int e = 9; e <= 11; e++) begin
      step();
      check($sformatf("haz_rel_e%0d", e), outs(), 4'b0010);
    end
    step_en(1'b1);  // edge 12: db[0] still 1, so the tick changes nothing
    check("haz_early_tick_e12", outs(), 4'b0010);
    for (int e = 13; e <= 20; e++) begin
      step();
      check($sformatf("haz_noen_e%0d", e), outs(), 4'b0010);
    end
    step_en(1'b1);  // edge 21: db[0] cleared at edge 14, tick leaves hazard
    check("haz_leave_e21", outs(), 4'b0001);
    step();
    check("haz_idle_e22", outs(), 4'b0000);

    // 5. Left and right together.
    auto_en = 1'b1;
    do_reset(3'b110);
`ifdef SWCOND_CONFLICT_HAZARD_EN
    for (int e = 1; e <= 6; e++) begin
      step();
      check($sformatf("conf_wait_e%0d", e), outs(), 4'b0000);
    end
    step();
    check("conf_haz_e7", outs(), 4'b0011);
    for (int e = 8; e <= 25; e++) begin
      step();
      check($sformatf("conf_hold_e%0d", e), outs(), 4'b0010);
    end
`else
    for (int e = 1; e <= 25; e++) begin
      step();
      check($sformatf("conf_idle_e%0d", e), outs(), 4'b0000);
    end
`endif

    // 6. Reset at edge 5 restarts debounce: db[1] set at edge 11, so the
    //    tick at edge 10 is too early and R commits at edge 20.
    do_reset(3'b010);
    for (int e = 1; e <= 4; e++) begin
      step();
      check($sformatf("mid_pre_e%0d", e), outs(), 4'b0000);
    end
    Reset = 1'b1;
    step();
    check("mid_reset_e5", outs(), 4'b0000);
    Reset = 1'b0;
    for (int e = 6; e <= 19; e++) begin
      step();
      check($sformatf("mid_wait_e%0d", e), outs(), 4'b0000);
    end
    step();
    check("mid_commit_e20", outs(), 4'b0101);
    step();
    check("mid_hold_e21", outs(), 4'b0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/taillight_switch_conditioner.md
# taillight_switch_conditioner

Input-conditioning stage that sits directly upstream of the taillight FSM. It takes the three raw, asynchronous board switches (left, right, hazard), synchronizes and debounces each one, and decodes them into a single mode. It presents that mode to the FSM as one-hot L/R/H levels. Mode changes are committed only on the 1 Hz `Enable` tick so the FSM never sees a request change mid-phase; the hazard request is the exception and commits on the next clock.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive cycles a synchronized switch must disagree with its debounced value before it is accepted (20 ms at 50 MHz). Legal range ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: width of each debounce counter.

Ports:
- `Clock`  in  1  system clock, 50 MHz.
- `Reset`  in  1  synchronous, active-high reset.
- `Enable`  in  1  one-cycle tick from the Timer, the same tick the FSM uses.
- `SwIn`  in  3  raw switches, asynchronous. [2] = left, [1] = right, [0] = hazard.
- `L`  out  1  committed left-turn request, to FSM `L`.
- `R`  out  1  committed right-turn request, to FSM `R`.
- `H`  out  1  committed hazard request, to FSM `H`.
- `Changed`  out  1  one-cycle pulse, high in the first cycle that a new committed mode is visible on L/R/H.

## Operation
- **Synchronizer**: two flops per bit. Reset value 0.
- **Debounce**: each bit i has a stable value `db[i]` and a counter `cnt[i]`.
  - If `sync[i] == db[i]`: `cnt[i] <= 0`.
  - Otherwise `cnt[i]` increments. When it reaches `DEBOUNCE_CYCLES-1` while still disagreeing, `db[i] <= sync[i]` and `cnt[i] <= 0`.
  - Any single cycle of agreement clears the counter, which rejects glitches.
  - Counters never wrap.
- **Decode**: combinational, from `db` to a pending mode, in priority order:
  - `db[0]` = 1 → HAZARD.
  - else `db[2]` & `db[1]` → see Configuration.
  - else `db[2]` → LEFT.
  - else `db[1]` → RIGHT.
  - else IDLE.
- **Commit register**: holds the committed mode, one of IDLE, LEFT, RIGHT, HAZARD.
  - IDLE: L=R=H=0.
  - LEFT: L=1, R=H=0.
  - RIGHT: R=1, L=H=0.
  - HAZARD: H=1, L=R=0.
  - At most one of L/R/H is ever high.
- **Transition rules**, evaluated each clock edge:
  - Pending = HAZARD and committed ≠ HAZARD → commit at this edge, regardless of `Enable`.
  - Otherwise, pending ≠ committed and `Enable` = 1 → commit.
  - Otherwise hold.
- `Changed` is registered. It is 1 in the cycle after any edge at which the committed value changed, and 0 otherwise.
- A request that appears and disappears between two `Enable` ticks is never committed. The exception is hazard, which has already committed immediately.

## Timing
- Reset values: sync flops = 0, `db` = 0, `cnt` = 0, committed mode = IDLE.
  - Hence L = R = H = 0 and `Changed` = 0 in every cycle while `Reset` is sampled high, and in the first cycle after.
- `Reset` dominates `Enable` and every debounce event.
- Reset asserted mid-debounce clears all counters. A switch still held after reset needs a full 2 + `DEBOUNCE_CYCLES` cycles again.
- Latency, raw edge to `db` update: 2 sync edges + `DEBOUNCE_CYCLES` edges, with the input held stable.
- `db` to outputs:
  - The decode is combinational, so HAZARD commits at the next edge after `db` updates.
  - Other modes commit at the first subsequent edge that samples `Enable` = 1.
  - `Enable` at the same edge that updates `db` acts on the old `db`.
- Leaving HAZARD follows the normal `Enable`-gated rule.
- Simultaneous changes on several bits each debounce independently. Decode always uses the current `db`.

## Configuration
- Macro `SWCOND_CONFLICT_HAZARD_EN`.
- **Defined**: left and right both debounced high (hazard low) decode to HAZARD. This uses the immediate-commit rule.
- **Undefined**: left and right both high decode to IDLE, so the FSM receives no turn request.

## Test plan
Bench settings: `DEBOUNCE_CYCLES` = 4, `Enable` pulsed every 10th cycle unless stated.

1. Reset: `SwIn` = 3'b111, `Reset` high for 3 cycles → L/R/H/`Changed` = 0 throughout and in the first post-reset cycle.
2. Left turn: `SwIn` = 3'b100 held from cycle 0 → `db[2]` set at edge 6; L = 1 at the first `Enable` edge ≥ 7; `Changed` high exactly 1 cycle; R = H = 0.
3. Glitch rejection: `SwIn[1]` high for 3 cycles then low, repeated 5 times → R, `Changed` stay 0.
4. Immediate hazard: `Enable` held 0, `SwIn` = 3'b001 at cycle 0 → H = 1 after edge 7; releasing `SwIn` leaves H = 1 until the next `Enable` tick after debounce.
5. Conflict: `SwIn` = 3'b110 → with the macro, H = 1 after 7 edges; without it, L = R = H = 0 and `Changed` never pulses.
6. Reset mid-debounce: `SwIn` = 3'b010, `Reset` pulsed at cycle 4 → R = 0 until a commit ≥ 7 cycles after reset release.
